decode_stage: RTL and testbench

//  Decode stage directly upstream of the ALU: accepts 32-bit RV32I instruction words (+PC) over valid/ready,

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/rv32i_decoder.sv | 93 +++++++++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module : rv32i_pkg
// Brief  : Shared RV32I decode types: opcode constants, ALU op codes and
//          the decoded-instruction record passed from decoder to execute.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_MUL = 4'b1100,
        ALU_DIV = 4'b1101
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu_ops;
        logic        is_lui;
        logic        is_i_type;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        illegal;
    } decoded_t;

endpackage

`default_nettype wire

// File: rtl/rv32i_decoder.sv
// ============================================================================
// Module : rv32i_decoder
// Brief  : Pure combinational RV32I instruction -> decoded_t translation.
//          Define DECODE_M_EXT_EN to decode MUL/DIV (funct7 = 0000001).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;
    alu_op_e    w_op;
    decoded_t   w_dec;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];

    always_comb begin
        w_dec          = '0;
        w_legal        = 1'b0;
        w_op           = ALU_ADD;
        w_dec.rs1_addr = i_instr[19:15];

        case (w_opcode)
            OPC_OP: begin
                w_dec.rs2_addr = i_instr[24:20];
                case (w_f7)
                    7'b0000000: begin
                        w_legal = 1'b1;
                        case (w_f3)
                            3'b000:  w_op = ALU_ADD;
                            3'b001:  w_op = ALU_SLL;
                            3'b100:  w_op = ALU_XOR;
                            3'b101:  w_op = ALU_SRL;
                            3'b110:  w_op = ALU_OR;
                            3'b111:  w_op = ALU_AND;
                            default: w_legal = 1'b0;
                        endcase
                    end
                    7'b0100000: begin
                        w_legal = (w_f3 == 3'b000);
                        w_op    = ALU_SUB;
                    end
`ifdef DECODE_M_EXT_EN
                    7'b0000001: begin
                        w_legal = 1'b1;
                        case (w_f3)
                            3'b000:  w_op = ALU_MUL;
                            3'b100:  w_op = ALU_DIV;
                            default: w_legal = 1'b0;
                        endcase
                    end
`endif
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                if (w_f3 == 3'b000) begin
                    w_legal         = 1'b1;
                    w_dec.is_i_type = 1'b1;
                    w_dec.imm       = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OPC_LUI: begin
                w_legal        = 1'b1;
                w_dec.is_lui   = 1'b1;
                w_dec.imm      = {12'b0, i_instr[31:12]};
                w_dec.rs1_addr = 5'd0;
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal words still travel down the pipe, but must never write back.
        w_dec.rd_addr = i_instr[11:7];
        w_dec.illegal = ~w_legal;
        w_dec.alu_ops = w_legal ? w_op : ALU_ADD;
        w_dec.rd_we   = w_legal && (i_instr[11:7] != 5'd0);
    end

    assign o_dec = w_dec;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module : decode_stage
// Brief  : RV32I decode stage with a 2-entry skid buffer (head + skid) in
//          front of execute. DECODE_M_EXT_EN enables MUL/DIV decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decode_stage
    import rv32i_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_ops,
    output logic            out_is_lui,
    output logic            out_is_i_type,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_we,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    decoded_t        w_dec;
    decoded_t        r_head;
    decoded_t        r_skid;
    logic [PC_W-1:0] r_head_pc;
    logic [PC_W-1:0] r_skid_pc;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_head;
    logic w_load_skid;
    logic w_promote;

    rv32i_decoder u_decoder (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign in_ready   = (r_state != ST_TWO);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_skid = 1'b0;
        w_promote   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_head = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_promote   = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_head = 1'b0;
            w_load_skid = 1'b0;
            w_promote   = 1'b0;
        end
    end

    // Head only changes on load/promote, so outputs stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_skid    <= '0;
            r_head_pc <= '0;
            r_skid_pc <= '0;
        end else if (flush) begin
            r_head    <= '0;
            r_skid    <= '0;
            r_head_pc <= '0;
            r_skid_pc <= '0;
        end else begin
            if (w_load_head) begin
                r_head    <= w_dec;
                r_head_pc <= in_pc;
            end else if (w_promote) begin
                r_head    <= r_skid;
                r_head_pc <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid    <= w_dec;
                r_skid_pc <= in_pc;
            end
        end
    end

    assign out_alu_ops   = r_head.alu_ops;
    assign out_is_lui    = r_head.is_lui;
    assign out_is_i_type = r_head.is_i_type;
    assign out_imm       = r_head.imm;
    assign out_rs1_addr  = r_head.rs1_addr;
    assign out_rs2_addr  = r_head.rs2_addr;
    assign out_rd_addr   = r_head.rd_addr;
    assign out_rd_we     = r_head.rd_we;
    assign out_illegal   = r_head.illegal;
    assign out_pc        = r_head_pc;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module : tb_decode_stage
// Brief  : Directed, table-driven checks of decode_stage decode, skid
//          buffering, flush and asynchronous reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_ops;
    logic        out_is_lui;
    logic        out_is_i_type;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    int n_checks;
    int n_errors;

    decode_stage #(.PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ops   (out_alu_ops),
        .out_is_lui    (out_is_lui),
        .out_is_i_type (out_is_i_type),
        .out_imm       (out_imm),
        .out_rs1_addr  (out_rs1_addr),
        .out_rs2_addr  (out_rs2_addr),
        .out_rd_addr   (out_rd_addr),
        .out_rd_we     (out_rd_we),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // full=0: imm/rs1/rs2 are not checked (format fields of illegal words)
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  alu;
        logic        lui;
        logic        itype;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        full;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [3:0] a,
                                input logic l, input logic it, input logic [31:0] im,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic we, input logic il, input logic f);
        vec_t v;
        v.name = n; v.instr = i; v.alu = a; v.lui = l; v.itype = it; v.imm = im;
        v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.we = we; v.ill = il; v.full = f;
        return v;
    endfunction

    logic [31:0] stream_instr[4];
    logic [31:0] stream_pc[4];
    logic [31:0] held_pc;

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = mk("add",   32'h002081B3, 4'b0000, 0, 0, 32'h0,        5'd1,  5'd2,  5'd3,  1, 0, 1);
        vecs[1]  = mk("addi-1",32'hFFF00293, 4'b0000, 0, 1, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd5,  1, 0, 1);
        vecs[2]  = mk("lui",   32'hABCDE3B7, 4'b0000, 1, 0, 32'h000ABCDE, 5'd0,  5'd0,  5'd7,  1, 0, 1);
        vecs[3]  = mk("nop",   32'h00000013, 4'b0000, 0, 1, 32'h0,        5'd0,  5'd0,  5'd0,  0, 0, 1);
        vecs[4]  = mk("opc7f", 32'h0000007F, 4'b0000, 0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0);
        vecs[5]  = mk("sub",   32'h40628233, 4'b0001, 0, 0, 32'h0,        5'd5,  5'd6,  5'd4,  1, 0, 1);
        vecs[6]  = mk("xor",   32'h009443B3, 4'b0010, 0, 0, 32'h0,        5'd8,  5'd9,  5'd7,  1, 0, 1);
        vecs[7]  = mk("sll",   32'h00C59533, 4'b0101, 0, 0, 32'h0,        5'd11, 5'd12, 5'd10, 1, 0, 1);
        vecs[8]  = mk("srl",   32'h00F756B3, 4'b0110, 0, 0, 32'h0,        5'd14, 5'd15, 5'd13, 1, 0, 1);
        vecs[9]  = mk("or",    32'h0128E833, 4'b0011, 0, 0, 32'h0,        5'd17, 5'd18, 5'd16, 1, 0, 1);
        vecs[10] = mk("and",   32'h01DF7FB3, 4'b0100, 0, 0, 32'h0,        5'd30, 5'd29, 5'd31, 1, 0, 1);
        vecs[11] = mk("addimx",32'h7FF10313, 4'b0000, 0, 1, 32'h000007FF, 5'd2,  5'd0,  5'd6,  1, 0, 1);
        vecs[12] = mk("slli",  32'h00109093, 4'b0000, 0, 0, 32'h0,        5'd1,  5'd0,  5'd1,  0, 1, 0);
        vecs[13] = mk("sra",   32'h40F756B3, 4'b0000, 0, 0, 32'h0,        5'd14, 5'd15, 5'd13, 0, 1, 0);
`ifdef DECODE_M_EXT_EN
        vecs[14] = mk("mul",   32'h023100B3, 4'b1100, 0, 0, 32'h0,        5'd2,  5'd3,  5'd1,  1, 0, 1);
        vecs[15] = mk("div",   32'h023140B3, 4'b1101, 0, 0, 32'h0,        5'd2,  5'd3,  5'd1,  1, 0, 1);
`else
        vecs[14] = mk("mul",   32'h023100B3, 4'b0000, 0, 0, 32'h0,        5'd2,  5'd3,  5'd1,  0, 1, 0);
        vecs[15] = mk("div",   32'h023140B3, 4'b0000, 0, 0, 32'h0,        5'd2,  5'd3,  5'd1,  0, 1, 0);
`endif

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;

        #12;
        check("reset_ctrl", {126'b0, out_valid, in_ready}, 128'b01);
        check("reset_data", {out_alu_ops, out_is_lui, out_is_i_type, out_imm, out_rs1_addr,
                             out_rs2_addr, out_rd_addr, out_rd_we, out_illegal, out_pc}, 128'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_instr  = vecs[i].instr;
            in_pc     = 32'h1000 + 32'(i * 4);
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({vecs[i].name, "_valid"}, {127'b0, out_valid}, 128'b1);
            check(vecs[i].name,
                  {out_alu_ops, out_is_lui, out_is_i_type,
                   vecs[i].full ? out_imm : vecs[i].imm,
                   vecs[i].full ? out_rs1_addr : vecs[i].rs1,
                   vecs[i].full ? out_rs2_addr : vecs[i].rs2,
                   out_rd_addr, out_rd_we, out_illegal, out_pc},
                  {vecs[i].alu, vecs[i].lui, vecs[i].itype, vecs[i].imm, vecs[i].rs1,
                   vecs[i].rs2, vecs[i].rd, vecs[i].we, vecs[i].ill, 32'h1000 + 32'(i * 4)});
        end
        @(posedge clk); #1;
        check("drain_empty", {126'b0, out_valid, in_ready}, 128'b01);

        // ---------------- backpressure stream ----------------
        for (int k = 0; k < 4; k++) begin
            stream_instr[k] = vecs[5 + k].instr;
            stream_pc[k]    = 32'h2000 + 32'(k * 4);
        end
        begin
            int idx;
            int got;
            logic in_x;
            logic out_x;
            idx = 0;
            got = 0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                in_valid  = (idx < 4);
                in_instr  = (idx < 4) ? stream_instr[idx] : 32'h0;
                in_pc     = (idx < 4) ? stream_pc[idx] : 32'h0;
                out_ready = (cyc >= 6);
                @(negedge clk);
                if (cyc == 2) held_pc = out_pc;
                if (cyc == 5) begin
                    check("bp_accepted", 128'(idx), 128'd2);
                    check("bp_in_ready", {127'b0, in_ready}, 128'b0);
                    check("bp_stable", {96'b0, out_pc}, {96'b0, held_pc});
                end
                in_x  = in_valid && in_ready;
                out_x = out_valid && out_ready;
                if (out_x) begin
                    check("bp_order", {96'b0, out_pc}, {96'b0, stream_pc[got]});
                    got++;
                end
                @(posedge clk); #1;
                if (in_x) idx++;
            end
            in_valid = 1'b0;
            check("bp_all_out", 128'(got), 128'd4);
        end

        // ---------------- flush with two entries held ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_instr = vecs[0].instr;
            in_pc    = 32'h3000 + 32'(k * 4);
            @(posedge clk); #1;
        end
        check("two_held", {126'b0, out_valid, in_ready}, 128'b10);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h3008;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_state", {126'b0, out_valid, in_ready}, 128'b01);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("flush_drop", {127'b0, out_valid}, 128'b0);

        // ---------------- asynchronous reset mid-stream ----------------
        in_valid = 1'b1;
        in_instr = vecs[2].instr;
        in_pc    = 32'h4000;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", {127'b0, out_valid}, 128'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {126'b0, out_valid, in_ready}, 128'b01);
        check("rst_data", {out_alu_ops, out_is_lui, out_is_i_type, out_imm, out_rs1_addr,
                           out_rs2_addr, out_rd_addr, out_rd_we, out_illegal, out_pc}, 128'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst", {127'b0, out_valid}, 128'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
